// File: rtl/wb_uart_fifo.sv
// Wishbone B3 slave UART (8N1, LSB first) with a programmable divisor, TX/RX FIFOs,
// sticky error flags, a maskable level interrupt and internal loopback.
module wb_uart_fifo #(
    parameter int                   FIFO_DEPTH = 16,
    parameter int                   DIV_WIDTH  = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(433),
    parameter int                   ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_sys_n,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    output logic                  irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [DIV_WIDTH:0]   HALF_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // Counts wider than the 8-bit STATUS fields (only at depth 256) read as 255.
    function automatic logic [7:0] cnt_field(input logic [PTR_W-1:0] c);
        logic [8:0] w;
        w = 9'(c);
        return w[8] ? 8'hFF : w[7:0];
    endfunction

    logic                 access, unmapped, acc_ok;
    logic [1:0]           reg_sel;
    logic                 wr_data, rd_data, wr_status, wr_ctrl, wr_div;
    logic [3:0]           ctrl;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 rxovr, ferr, txovf;
    logic [31:0]          rdata;
    logic                 unused_ok;

    assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign unmapped  = |wb_adr_i[ADDR_WIDTH-1:4];
    assign acc_ok    = access & ~unmapped;
    assign reg_sel   = wb_adr_i[3:2];
    assign wr_data   = acc_ok & wb_we_i & (reg_sel == 2'd0) & wb_sel_i[0];
    assign rd_data   = acc_ok & ~wb_we_i & (reg_sel == 2'd0);
    assign wr_status = acc_ok & wb_we_i & (reg_sel == 2'd1);
    assign wr_ctrl   = acc_ok & wb_we_i & (reg_sel == 2'd2);
    assign wr_div    = acc_ok & wb_we_i & (reg_sel == 2'd3);
    assign wb_rty_o  = 1'b0;
    assign unused_ok = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i};

    // TX FIFO: bus pushes, TX FSM pops
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wptr, tx_rptr, tx_count;
    logic             tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_count = tx_wptr - tx_rptr;
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[IDX_W] != tx_rptr[IDX_W]) &&
                      (tx_wptr[IDX_W-1:0] == tx_rptr[IDX_W-1:0]);
    assign tx_head  = tx_mem[tx_rptr[IDX_W-1:0]];
    assign tx_push  = wr_data & (~tx_full | tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[IDX_W-1:0]] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end

    // RX FIFO: RX FSM pushes, DATA reads pop
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wptr, rx_rptr, rx_count;
    logic             rx_empty, rx_full, rx_push, rx_pop, rx_push_req;
    logic [7:0]       rx_head, rx_sh;

    assign rx_count = rx_wptr - rx_rptr;
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[IDX_W] != rx_rptr[IDX_W]) &&
                      (rx_wptr[IDX_W-1:0] == rx_rptr[IDX_W-1:0]);
    assign rx_head  = rx_mem[rx_rptr[IDX_W-1:0]];
    assign rx_pop   = rd_data & ~rx_empty;
    assign rx_push  = rx_push_req & (~rx_full | rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr[IDX_W-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    // TX FSM: uart_tx is registered so the line never glitches between bits
    uart_state_t          tx_state, tx_state_n;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [7:0]           tx_sh, tx_sh_n;
    logic                 tx_line, tx_line_n, tx_tick, tx_idle;

    assign tx_tick = (tx_cnt == tx_div);
    assign tx_idle = tx_empty & (tx_state == S_IDLE);
    assign uart_tx = tx_line;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = S_START;
                    tx_sh_n    = tx_head;
                    tx_div_n   = div_reg;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b0;
                end
            end
            S_START: begin
                if (tx_tick) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = S_DATA;
                    tx_line_n  = tx_sh[0];
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_sh_n   = {1'b0, tx_sh[7:1]};
                        tx_line_n = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_n = S_START;
                        tx_sh_n    = tx_head;
                        tx_div_n   = div_reg;
                        tx_line_n  = 1'b0;
                    end else begin
                        tx_state_n = S_IDLE;
                        tx_line_n  = 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
    end

    // RX synchronizer; loopback feeds the TX line into the same path
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= ctrl[3] ? tx_line : uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX FSM: START waits half a bit, then DATA/STOP sample at bit centres
    uart_state_t          rx_state, rx_state_n;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [7:0]           rx_sh_n;
    logic                 rx_tick, rx_half_done, ferr_set;
    logic [DIV_WIDTH:0]   rx_half;

    assign rx_tick      = (rx_cnt == rx_div);
    assign rx_half      = ({1'b0, rx_div} + HALF_ONE) >> 1;
    assign rx_half_done = (({1'b0, rx_cnt} + HALF_ONE) >= rx_half);

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
        end
    end

    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_div_n    = rx_div;
        rx_bit_n    = rx_bit;
        rx_sh_n     = rx_sh;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n = S_START;
                    rx_cnt_n   = '0;
                    rx_div_n   = div_reg;
                end
            end
            S_START: begin
                if (rx_half_done) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rx_sync, rx_sh[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_cnt_n    = '0;
                    rx_state_n  = S_IDLE;
                    rx_push_req = rx_sync;
                    ferr_set    = ~rx_sync;
                end else begin
                    rx_cnt_n = rx_cnt + CNT_ONE;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // Register file, sticky flags (set wins over a same-cycle clear) and read mux
    logic       rxovr_set, txovf_set, irq_n;
    logic [2:0] flag_clr;

    assign rxovr_set = rx_push_req & rx_full & ~rx_pop;
    assign txovf_set = wr_data & tx_full & ~tx_pop;
    assign flag_clr  = wr_status ? wb_dat_i[5:3] : 3'b000;
    assign irq_n     = (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_idle) |
                       (ctrl[2] & (rxovr | ferr | txovf));

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0:    rdata = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
            2'd1:    rdata = {8'h00, cnt_field(tx_count), cnt_field(rx_count), 2'b00,
                              txovf, ferr, rxovr, tx_idle, tx_full, ~rx_empty};
            2'd2:    rdata = {28'd0, ctrl};
            default: rdata = 32'(div_reg);
        endcase
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            ctrl     <= '0;
            div_reg  <= DIV_RESET;
            rxovr    <= 1'b0;
            ferr     <= 1'b0;
            txovf    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            wb_ack_o <= acc_ok;
            wb_err_o <= access & unmapped;
            if (acc_ok & ~wb_we_i) wb_dat_o <= rdata;
            if (wr_ctrl) ctrl <= wb_dat_i[3:0];
            if (wr_div)  div_reg <= wb_dat_i[DIV_WIDTH-1:0];
            rxovr <= (rxovr & ~flag_clr[0]) | rxovr_set;
            ferr  <= (ferr  & ~flag_clr[1]) | ferr_set;
            txovf <= (txovf & ~flag_clr[2]) | txovf_set;
            irq   <= irq_n;
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo.sv
// Self-checking bench for wb_uart_fifo: bus timing, TX framing, loopback, overflow,
// framing error, glitch reject, unmapped access and mid-frame reset.
module tb_wb_uart_fifo;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_sys_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        uart_rx, uart_tx, irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_q[$];
    logic       bit_q[$];

    always #5 clk = ~clk;

    wb_uart_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_sys_n(rst_sys_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    // One bus access; lat = cycles from strobe to ack/err (8 if none arrives)
    task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       output logic [31:0] rd, output logic ack, output logic err,
                       output int lat);
        @(negedge clk);
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        rd = '0; ack = 1'b0; err = 1'b0; lat = 8;
        for (int i = 1; i <= 8 && lat == 8; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o || wb_err_o) begin
                ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; lat = i;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd; logic ack, err; int lat;
        bus(adr, dat, 1'b1, rd, ack, err, lat);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] data);
        logic ack, err; int lat;
        bus(adr, 32'd0, 1'b0, data, ack, err, lat);
        if (!ack) data = 32'hDEAD_BEEF;
    endtask

    task automatic poll_status(input logic [31:0] mask, input logic [31:0] val,
                               input int max_polls, output logic [31:0] st, output logic ok);
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < max_polls && !ok; i++) begin
            rd(32'h4, st);
            if ((st & mask) == val) ok = 1'b1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop_v;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ack, err; int lat;
        rst_sys_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1 || irq !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: tx=%b irq=%b ack=%b err=%b, expected tx=1 irq=0 ack=0 err=0",
                     uart_tx, irq, wb_ack_o, wb_err_o);
        end
        @(negedge clk) rst_sys_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL idle_ack: ack=%b expected 0", wb_ack_o);
        end
        bus(32'h4, 32'd0, 1'b0, d, ack, err, lat);
        checks++;
        if (lat !== 1 || ack !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL status_ack_timing: lat=%0d ack=%b err=%b expected lat=1 ack=1 err=0", lat, ack, err);
        end
        checks++;
        if (d !== 32'h4) begin
            failures++; $display("FAIL reset_status: got %h expected 00000004", d);
        end
        checks++;
        if (wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL ack_one_cycle: ack=%b expected 0", wb_ack_o);
        end
        rd(32'hC, d);
        checks++;
        if (d !== 32'd433) begin
            failures++; $display("FAIL reset_div: got %0d expected 433", d);
        end
        rd(32'h8, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL reset_ctrl: got %h expected 0", d);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        @(negedge clk);
        wb_adr_i = 32'h4; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp = (i % 2 == 0);
            checks++;
            if (wb_ack_o !== exp) begin
                failures++; $display("FAIL back_to_back_ack[%0d]: ack=%b expected %b", i, wb_ack_o, exp);
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tx_frame();
        logic [7:0]  b;
        logic [31:0] d;
        logic        found, exp, good, seen;
        wr(32'hC, 32'd3);
        b = 8'hA5;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
        bit_q.push_back(1'b1);
        wr(32'h0, {24'd0, b});
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (uart_tx === 1'b0) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL tx_start_bit: line stayed %b expected 0", uart_tx);
        end
        for (int k = 0; k < 10; k++) begin
            exp = bit_q.pop_front();
            good = 1'b1;
            seen = exp;
            for (int s = 0; s < 4; s++) begin
                if (!(k == 0 && s == 0)) begin @(posedge clk); #1; end
                if (uart_tx !== exp) begin good = 1'b0; seen = uart_tx; end
            end
            checks++;
            if (!good) begin
                failures++; $display("FAIL tx_bit[%0d]: line=%b expected %b", k, seen, exp);
            end
        end
        @(posedge clk);
        rd(32'h4, d);
        checks++;
        if (d !== 32'h4) begin
            failures++; $display("FAIL tx_idle_after_stop: status=%h expected 00000004", d);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] d, st;
        logic [7:0]  bytes [3];
        logic        ok;
        bytes[0] = 8'h3C; bytes[1] = 8'hFF; bytes[2] = 8'h00;
        wr(32'h8, 32'h8);
        for (int i = 0; i < 3; i++) begin
            wr(32'h0, {24'd0, bytes[i]});
            sb_q.push_back(bytes[i]);
        end
        poll_status(32'h0000_FF00, 32'h0000_0300, 150, st, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL loopback_rx_count: status=%h expected rx_count 3", st);
        end
        for (int i = 0; i < 3; i++) begin
            rd(32'h0, d);
            checks++;
            if (d !== {23'd0, 1'b1, sb_q[0]}) begin
                failures++; $display("FAIL loopback_data[%0d]: got %h expected %h", i, d, {23'd0, 1'b1, sb_q[0]});
            end
            void'(sb_q.pop_front());
        end
        rd(32'h0, d);
        checks++;
        if (d !== 32'd0) begin
            failures++; $display("FAIL loopback_empty_read: got %h expected 0", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, st;
        logic        ok;
        wr(32'h8, 32'hC);
        for (int i = 1; i <= 5; i++) begin
            wr(32'h0, 32'(8'h11 * i));
            if (i <= DEPTH) sb_q.push_back(8'(8'h11 * i));
        end
        poll_status(32'h8, 32'h8, 200, st, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rxovr_set: status=%h expected bit3 set", st);
        end
        checks++;
        if (st[15:8] !== 8'(DEPTH) || st[5:4] !== 2'b00) begin
            failures++; $display("FAIL overflow_status: rx_count=%0d ferr_txovf=%b expected %0d and 00", st[15:8], st[5:4], DEPTH);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL overflow_irq: irq=%b expected 1", irq);
        end
        wr(32'h4, 32'h8);
        rd(32'h4, d);
        checks++;
        if (d[3] !== 1'b0 || d[15:8] !== 8'(DEPTH)) begin
            failures++; $display("FAIL rxovr_clear: status=%h expected bit3=0 rx_count=%0d", d, DEPTH);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_after_clear: irq=%b expected 0", irq);
        end
        while (sb_q.size() > 0) begin
            rd(32'h0, d);
            checks++;
            if (d !== {23'd0, 1'b1, sb_q[0]}) begin
                failures++; $display("FAIL overflow_data: got %h expected %h", d, {23'd0, 1'b1, sb_q[0]});
            end
            void'(sb_q.pop_front());
        end
        wr(32'h8, 32'h0);
    endtask

    task automatic test_rx_ext();
        logic [31:0] d;
        send_rx(8'h55, 1'b0);
        rd(32'h4, d);
        checks++;
        if (d[4] !== 1'b1 || d[15:8] !== 8'd0) begin
            failures++; $display("FAIL ferr_frame: status=%h expected FERR=1 rx_count=0", d);
        end
        wr(32'h4, 32'h10);
        rd(32'h4, d);
        checks++;
        if (d !== 32'h4) begin
            failures++; $display("FAIL ferr_clear: status=%h expected 00000004", d);
        end
        sb_q.push_back(8'h96);
        send_rx(8'h96, 1'b1);
        rd(32'h0, d);
        checks++;
        if (d !== {23'd0, 1'b1, sb_q[0]}) begin
            failures++; $display("FAIL ext_rx_data: got %h expected %h", d, {23'd0, 1'b1, sb_q[0]});
        end
        void'(sb_q.pop_front());
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        rd(32'h4, d);
        checks++;
        if (d !== 32'h4) begin
            failures++; $display("FAIL glitch_reject: status=%h expected 00000004", d);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic ack, err; int lat;
        bus(32'h10, 32'h41, 1'b1, d, ack, err, lat);
        checks++;
        if (lat !== 1 || err !== 1'b1 || ack !== 1'b0) begin
            failures++; $display("FAIL unmapped_write: lat=%0d err=%b ack=%b expected lat=1 err=1 ack=0", lat, err, ack);
        end
        checks++;
        if (wb_err_o !== 1'b0) begin
            failures++; $display("FAIL err_one_cycle: err=%b expected 0", wb_err_o);
        end
        bus(32'h14, 32'h0, 1'b0, d, ack, err, lat);
        checks++;
        if (err !== 1'b1 || ack !== 1'b0) begin
            failures++; $display("FAIL unmapped_read: err=%b ack=%b expected err=1 ack=0", err, ack);
        end
        repeat (6) @(posedge clk);
        rd(32'h4, d);
        checks++;
        if (d !== 32'h4 || uart_tx !== 1'b1) begin
            failures++; $display("FAIL unmapped_no_effect: status=%h tx=%b expected 00000004 and 1", d, uart_tx);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        logic        found;
        wr(32'h0, 32'h0F);
        wr(32'h0, 32'hF0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (uart_tx === 1'b0) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL mid_tx_start: line=%b expected 0", uart_tx);
        end
        @(negedge clk) rst_sys_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++; $display("FAIL async_reset_tx: line=%b expected 1", uart_tx);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_sys_n = 1'b1;
        rd(32'h4, d);
        checks++;
        if (d !== 32'h4) begin
            failures++; $display("FAIL post_reset_status: status=%h expected 00000004", d);
        end
        rd(32'hC, d);
        checks++;
        if (d !== 32'd433 || uart_tx !== 1'b1) begin
            failures++; $display("FAIL post_reset_div: div=%0d tx=%b expected 433 and 1", d, uart_tx);
        end
    endtask

    initial begin
        rst_sys_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        test_back_to_back();
        test_tx_frame();
        test_loopback();
        test_overflow();
        test_rx_ext();
        test_unmapped();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
